// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction queue.
// The master side is the fetch/decode pair; the slave side is the queue itself.
interface if_id_queue_if #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          if_valid;
   logic [AW-1:0] if_pc;
   logic [DW-1:0] if_inst;
   logic          if_ready;
   logic          id_valid;
   logic [AW-1:0] id_pc;
   logic [DW-1:0] id_inst;
   logic          id_ready;
   logic [CW-1:0] count;

   modport master (
      output if_valid, if_pc, if_inst, id_ready,
      input  if_ready, id_valid, id_pc, id_inst, count
   );

   modport slave (
      input  if_valid, if_pc, if_inst, id_ready,
      output if_ready, id_valid, id_pc, id_inst, count
   );
endinterface

// File: rtl/if_id_queue.sv
// Instruction fetch queue: buffers DEPTH {pc, inst} pairs between fetch and decode.
// When the queue is empty, decode sees an all-zero NOP bubble. A flush drops every buffered entry.
module if_id_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   if_id_queue_if.slave q
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   logic [AW-1:0] pc_mem_q   [DEPTH];
   logic [DW-1:0] inst_mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;

   logic not_full;
   logic not_empty;
   logic push;
   logic pop;

   assign not_full  = (count_q != FULL_CNT);
   assign not_empty = (count_q != {CW{1'b0}});
   assign push      = q.if_valid & not_full  & ~flush;
   assign pop       = not_empty  & q.id_ready & ~flush;

   // Pointer and occupancy next-state. The power-of-two depth makes the pointers wrap on their own.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = {PW{1'b0}};
         rd_ptr_d = {PW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset. Stale contents are never visible because id_* are gated by occupancy.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]   <= q.if_pc;
         inst_mem_q[wr_ptr_q] <= q.if_inst;
      end
   end

   assign q.if_ready = not_full;
   assign q.id_valid = not_empty;
   assign q.id_pc    = not_empty ? pc_mem_q[rd_ptr_q]   : {AW{1'b0}};
   assign q.id_inst  = not_empty ? inst_mem_q[rd_ptr_q] : {DW{1'b0}};
   assign q.count    = count_q;
endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: directed scenarios followed by random traffic.
// Expected entries are queued as pushes are accepted, and a monitor compares them against the head of the DUT.
module tb_if_id_queue;
   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [DW-1:0] inst;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   ent_t exp_q [$];
   int   total  = 0;
   int   bad    = 0;
   int   popped = 0;

   always #5 clk = ~clk;

   if_id_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

   if_id_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .q     (bus)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: runs mid-cycle, after the inputs have settled and before the next rising edge.
   initial begin
      int sz;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            sz = exp_q.size();
            chk("count", 64'(bus.count), 64'(sz));
            chk("id_valid", 64'(bus.id_valid), 64'(sz != 0));
            chk("if_ready", 64'(bus.if_ready), 64'(sz != DEPTH));
            if (sz == 0) begin
               chk("bubble_pc", 64'(bus.id_pc), 64'd0);
               chk("bubble_inst", 64'(bus.id_inst), 64'd0);
            end else begin
               chk("head_pc", 64'(bus.id_pc), 64'(exp_q[0].pc));
               chk("head_inst", 64'(bus.id_inst), 64'(exp_q[0].inst));
            end
            if (flush) begin
               exp_q.delete();
            end else if (sz != 0 && bus.id_ready) begin
               void'(exp_q.pop_front());
               popped++;
            end
         end
      end
   end

   task automatic step(input logic v, input logic [AW-1:0] pc, input logic [DW-1:0] inst,
                       input logic rdy, input logic fl);
      bit   acc;
      ent_t e;
      @(negedge clk);
      bus.if_valid = v;
      bus.if_pc    = pc;
      bus.if_inst  = inst;
      bus.id_ready = rdy;
      flush        = fl;
      #1;
      acc = v && !fl && (exp_q.size() != DEPTH);
      @(posedge clk);
      if (acc) begin
         e.pc   = pc;
         e.inst = inst;
         exp_q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      bus.if_valid = 1'b0;
      bus.id_ready = 1'b0;
      flush        = 1'b0;
      #3;
      rst = 1'b1;
      exp_q.delete();
      #1;
      chk("rst_count", 64'(bus.count), 64'd0);
      chk("rst_id_valid", 64'(bus.id_valid), 64'd0);
      chk("rst_id_inst", 64'(bus.id_inst), 64'd0);
      chk("rst_id_pc", 64'(bus.id_pc), 64'd0);
      chk("rst_if_ready", 64'(bus.if_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int p0;
      rst          = 1'b1;
      flush        = 1'b0;
      bus.if_valid = 1'b0;
      bus.if_pc    = 32'd0;
      bus.if_inst  = 32'd0;
      bus.id_ready = 1'b0;
      #1;
      chk("init_count", 64'(bus.count), 64'd0);
      chk("init_id_valid", 64'(bus.id_valid), 64'd0);
      chk("init_if_ready", 64'(bus.if_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      idle(1);

      // Fill to full, attempt an extra push, then drain in order.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(i * 4), 32'h1000 + 32'(i), 1'b0, 1'b0);
      step(1'b1, 32'h10, 32'hDEAD, 1'b0, 1'b0);
      p0 = popped;
      for (int i = 0; i < DEPTH; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      chk("drain_pops", 64'(popped - p0), 64'd4);
      idle(1);

      // Streaming with pushes and pops in the same cycle.
      p0 = popped;
      for (int i = 0; i < 12; i++) step(1'b1, 32'(i * 4), 32'h2000 + 32'(i), 1'b1, 1'b0);
      chk("stream_pops", 64'(popped - p0), 64'd11);
      idle(2);

      // Full queue with a pop in the same cycle: the push is blocked.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h40 + 32'(i * 4), 32'h3000 + 32'(i), 1'b0, 1'b0);
      step(1'b1, 32'h50, 32'h3050, 1'b1, 1'b0);
      idle(1);

      // Flush with count=3; the push and pop in the flush cycle are both dropped.
      step(1'b1, 32'h60, 32'h3060, 1'b1, 1'b1);
      idle(1);
      step(1'b1, 32'h100, 32'h4100, 1'b0, 1'b0);
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      idle(1);

      // Reset mid-stream.
      step(1'b1, 32'h180, 32'h5180, 1'b0, 1'b0);
      step(1'b1, 32'h184, 32'h5184, 1'b0, 1'b0);
      pulse_reset();
      step(1'b1, 32'h200, 32'h6200, 1'b0, 1'b0);
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      idle(1);

      // Random traffic, including occasional flushes.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, $urandom(), $urandom(),
              $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
      end
      for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      #2;
      chk("final_count", 64'(bus.count), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
